// File: rtl/alu_op_issuer_if.sv
// Command, response and ALU-drive bundle for alu_op_issuer.
// slave = issuer side, master = requester/ALU-environment side.
interface alu_op_issuer_if #(
  parameter int DATA_W = 16,
  parameter int RES_W  = 32
);
  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; once raised, valid and its payload hold until that transfer.
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              cmd_src_a;
  logic [1:0]        cmd_src_b;

  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_mux_a;
  logic [3:0]        alu_mux_b;
  logic              alu_reset;
  logic [RES_W-1:0]  alu_result;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [RES_W-1:0]  rsp_data;
  logic [3:0]        rsp_op;
  logic              rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_src_a, cmd_src_b,
    input  alu_result, rsp_ready,
    output cmd_ready, alu_op, alu_a, alu_b, alu_mux_a, alu_mux_b, alu_reset,
    output rsp_valid, rsp_data, rsp_op, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_src_a, cmd_src_b,
    output alu_result, rsp_ready,
    input  cmd_ready, alu_op, alu_a, alu_b, alu_mux_a, alu_mux_b, alu_reset,
    input  rsp_valid, rsp_data, rsp_op, rsp_err
  );
endinterface

// File: rtl/alu_op_issuer.sv
// Command front end for the 16-bit ALU: issues one op, waits LAT cycles, returns the result.
// Optional: define ALU_ISSUE_DIVZERO_EN to reject op 3 with an effective B of zero.
module alu_op_issuer #(
  parameter int DATA_W = 16,
  parameter int RES_W  = 32,
  parameter int LAT    = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  alu_op_issuer_if.slave bus,
  output logic [1:0]     o_dbg_state
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_NOP   = 4'd13;
  localparam logic [3:0] OP_ERR   = 4'd14;
  localparam logic [3:0] OP_RESET = 4'd15;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_src_a;
  logic [1:0]        r_src_b;
  logic [3:0]        r_alu_op;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic              r_alu_reset;
  logic [RES_W-1:0]  r_rsp_data;
  logic [3:0]        r_rsp_op;
  logic              r_rsp_err;
  logic [RES_W-1:0]  r_acc_q;
  logic [DATA_W-1:0] r_held_a;
  logic [DATA_W-1:0] r_held_b;

  logic              w_fire;
  logic [DATA_W-1:0] w_a_eff;
  logic [DATA_W-1:0] w_b_eff;
  logic              w_special;
  logic              w_divzero;

  assign w_fire    = bus.cmd_valid && (r_state == S_IDLE);
  assign w_a_eff   = bus.cmd_src_a ? bus.cmd_a : r_held_a;
  assign w_special = (bus.cmd_op == OP_NOP) || (bus.cmd_op == OP_ERR) ||
                     (bus.cmd_op == OP_RESET);

  // Effective B mirrors what the ALU's B register will hold after the issue.
  always_comb begin
    w_b_eff = r_held_b;
    case (bus.cmd_src_b)
      2'd0:    w_b_eff = r_held_b;
      2'd1:    w_b_eff = r_acc_q[DATA_W-1:0];
      2'd2:    w_b_eff = bus.cmd_b;
      default: w_b_eff = '0;
    endcase
  end

`ifdef ALU_ISSUE_DIVZERO_EN
  assign w_divzero = (bus.cmd_op == OP_DIV) && (w_b_eff == '0);
`else
  assign w_divzero = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_src_a     <= 1'b0;
      r_src_b     <= 2'd0;
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_reset <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_op    <= '0;
      r_rsp_err   <= 1'b0;
      r_acc_q     <= '0;
      r_held_a    <= '0;
      r_held_b    <= '0;
    end else begin
      r_alu_reset <= w_fire && (bus.cmd_op == OP_RESET);
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_rsp_op <= bus.cmd_op;
            if (w_special || w_divzero) begin
              r_state <= S_RESP;
              case (bus.cmd_op)
                OP_NOP: begin
                  r_rsp_data <= r_acc_q;
                  r_rsp_err  <= 1'b0;
                end
                OP_RESET: begin
                  r_rsp_data <= '0;
                  r_rsp_err  <= 1'b0;
                  r_acc_q    <= '0;
                end
                default: begin
                  r_rsp_data <= '0;
                  r_rsp_err  <= 1'b1;
                end
              endcase
            end else begin
              r_state  <= S_ISSUE;
              r_src_a  <= bus.cmd_src_a;
              r_src_b  <= bus.cmd_src_b;
              r_alu_op <= bus.cmd_op;
              r_alu_a  <= w_a_eff;
              r_alu_b  <= w_b_eff;
              r_held_a <= w_a_eff;
              r_held_b <= w_b_eff;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= CNT_W'(LAT - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_data <= bus.alu_result;
            r_rsp_err  <= 1'b0;
            r_acc_q    <= bus.alu_result;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          if (bus.rsp_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Selects are one-hot and only leave "hold" during the ISSUE cycle.
  always_comb begin
    bus.alu_mux_a = 2'b01;
    bus.alu_mux_b = 4'b0001;
    if (r_state == S_ISSUE) begin
      bus.alu_mux_a = r_src_a ? 2'b10 : 2'b01;
      case (r_src_b)
        2'd0:    bus.alu_mux_b = 4'b0001;
        2'd1:    bus.alu_mux_b = 4'b0010;
        2'd2:    bus.alu_mux_b = 4'b0100;
        default: bus.alu_mux_b = 4'b1000;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_op    = r_rsp_op;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_reset = r_alu_reset;
  assign o_dbg_state   = r_state;
endmodule
